// File: rtl/ahb_slave_mem.sv
// AHB-Lite word-addressed memory slave with a configurable number of OKAY wait
// states and a two-cycle ERROR response for out-of-range or misaligned accesses.
module ahb_slave_mem #(
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic        hclk,
   input  logic        hrst,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic [3:0]  hprot,
   input  logic        hexcl,
   input  logic [31:0] hwdata,
   output logic [31:0] hrdata,
   output logic        hreadyout,
   output logic [1:0]  hresp
);

   // state   | meaning
   // IDLE    | zero-wait OKAY data phase (or no transfer)
   // WAIT    | OKAY data phase stalled; completes when cnt reaches 0
   // ERR1    | first ERROR cycle, hreadyout low
   // ERR2    | second ERROR cycle, hreadyout high
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ERR1 = 2'd2;
   localparam logic [1:0] ST_ERR2 = 2'd3;

   localparam int          AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);
   localparam logic [3:0]  WS      = 4'(WAIT_STATES);

   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [31:0]   hrdata_q, hrdata_d;
   logic          dp_wr_q, dp_wr_d;
   logic          dp_rd_q, dp_rd_d;
   logic [AW-1:0] dp_idx_q, dp_idx_d;
   logic [3:0]    dp_strb_q, dp_strb_d;
   logic [31:0]   mem_q [MEM_DEPTH];

   logic          ready;
   logic          accept;
   logic          addr_err;
   logic          wr_commit;
   logic [AW-1:0] a_idx;
   logic [AW-1:0] rd_idx;
   logic [3:0]    a_strb;
   logic [31:0]   rd_word;
   logic          unused_ok;

   assign unused_ok = ^{hburst, hprot, hexcl, htrans[0]};

   assign ready     = (state_q == ST_IDLE) || (state_q == ST_ERR2) ||
                      ((state_q == ST_WAIT) && (cnt_q == 4'd0));
   assign accept    = ready && hsel && htrans[1];
   assign wr_commit = ready && dp_wr_q;
   assign a_idx     = haddr[AW+1:2];
   assign rd_idx    = ready ? a_idx : dp_idx_q;

   always_comb begin
      addr_err = 1'b0;
      if ({2'b00, haddr[31:2]} >= DEPTH_W)                addr_err = 1'b1;
      if (hsize > 3'd2)                                   addr_err = 1'b1;
      if ((hsize == 3'd1) && haddr[0])                    addr_err = 1'b1;
      if ((hsize == 3'd2) && (haddr[1:0] != 2'b00))       addr_err = 1'b1;
   end

   always_comb begin
      case (hsize)
         3'd0:    a_strb = 4'b0001 << haddr[1:0];
         3'd1:    a_strb = haddr[1] ? 4'b1100 : 4'b0011;
         default: a_strb = 4'b1111;
      endcase
   end

   // A write committing on the same edge must be visible to a read loaded there.
   always_comb begin
      rd_word = mem_q[rd_idx];
      if (wr_commit && (dp_idx_q == rd_idx)) begin
         for (int i = 0; i < 4; i++) begin
            if (dp_strb_q[i]) rd_word[8*i +: 8] = hwdata[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hrdata_d  = hrdata_q;
      dp_wr_d   = dp_wr_q;
      dp_rd_d   = dp_rd_q;
      dp_idx_d  = dp_idx_q;
      dp_strb_d = dp_strb_q;
      if (ready) begin
         state_d = ST_IDLE;
         cnt_d   = 4'd0;
         dp_wr_d = 1'b0;
         dp_rd_d = 1'b0;
         if (accept) begin
            dp_idx_d  = a_idx;
            dp_strb_d = a_strb;
            if (addr_err) begin
               state_d = ST_ERR1;
               if (!hwrite) hrdata_d = '0;
            end else begin
               dp_wr_d = hwrite;
               dp_rd_d = !hwrite;
               if (WS != 4'd0) begin
                  state_d = ST_WAIT;
                  cnt_d   = WS;
               end else if (!hwrite) begin
                  hrdata_d = rd_word;
               end
            end
         end
      end else if (state_q == ST_ERR1) begin
         state_d = ST_ERR2;
      end else begin
         cnt_d = cnt_q - 4'd1;
         if ((cnt_q == 4'd1) && dp_rd_q) hrdata_d = rd_word;
      end
   end

   always_ff @(posedge hclk or posedge hrst) begin
      if (hrst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         hrdata_q  <= '0;
         dp_wr_q   <= 1'b0;
         dp_rd_q   <= 1'b0;
         dp_idx_q  <= '0;
         dp_strb_q <= 4'b0000;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hrdata_q  <= hrdata_d;
         dp_wr_q   <= dp_wr_d;
         dp_rd_q   <= dp_rd_d;
         dp_idx_q  <= dp_idx_d;
         dp_strb_q <= dp_strb_d;
      end
   end

   // Memory keeps its contents across reset; an aborted write never reaches here
   // because dp_wr_q is cleared asynchronously.
   always_ff @(posedge hclk) begin
      if (wr_commit) begin
         for (int i = 0; i < 4; i++) begin
            if (dp_strb_q[i]) mem_q[dp_idx_q][8*i +: 8] <= hwdata[8*i +: 8];
         end
      end
   end

   assign hreadyout = ready;
   assign hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
   assign hrdata    = hrdata_q;

endmodule
